// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit owning the HI/LO register pair.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes.
module mul_div_unit #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [1:0]       MdOp,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic             HiWrite,
    input  logic             LoWrite,
    input  logic [WIDTH-1:0] WrData,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int CW = $clog2(ITER);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    logic [1:0]         r_state;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_b;
    logic               r_isdiv;
    logic               r_nega;
    logic               r_negr;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;
    logic               r_dz;

    logic               w_signed;
    logic               w_nega;
    logic               w_negb;
    logic [WIDTH-1:0]   w_absa;
    logic [WIDTH-1:0]   w_absb;
    logic               w_accept;
    logic               w_last;
    logic               w_bzero;

    logic [WIDTH:0]     w_madd;
    logic [WIDTH-1:0]   w_mul_acc;
    logic [WIDTH-1:0]   w_mul_q;

    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_trial;
    logic               w_ge;
    logic [WIDTH-1:0]   w_div_acc;
    logic [WIDTH-1:0]   w_div_q;

    logic [WIDTH-1:0]   w_next_acc;
    logic [WIDTH-1:0]   w_next_q;

    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_s;
    logic [WIDTH-1:0]   w_quo_s;
    logic [WIDTH-1:0]   w_rem_s;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;

    assign w_signed = ~MdOp[0];
    assign w_nega   = w_signed & SrcA[WIDTH-1];
    assign w_negb   = w_signed & SrcB[WIDTH-1];
    assign w_absa   = w_nega ? -SrcA : SrcA;
    assign w_absb   = w_negb ? -SrcB : SrcB;

    assign w_accept = Start & (r_state != S_RUN);
    assign w_last   = (r_state == S_RUN) && (r_cnt == CW'(ITER - 1));
    assign w_bzero  = (r_b == '0);

    // Multiply step: add multiplicand when the low multiplier bit is set,
    // then shift the {acc,q} pair right so product bits fill q from the top.
    assign w_madd    = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : '0);
    assign w_mul_acc = w_madd[WIDTH:1];
    assign w_mul_q   = {w_madd[0], r_q[WIDTH-1:1]};

    // Divide step: shift the next dividend bit into the remainder and
    // keep the subtraction only if it did not borrow.
    assign w_shift   = {r_acc, r_q[WIDTH-1]};
    assign w_trial   = w_shift - {1'b0, r_b};
    assign w_ge      = ~w_trial[WIDTH];
    assign w_div_acc = w_ge ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_div_q   = {r_q[WIDTH-2:0], w_ge};

    assign w_next_acc = r_isdiv ? w_div_acc : w_mul_acc;
    assign w_next_q   = r_isdiv ? w_div_q : w_mul_q;

    // Signs are applied only to the final step's magnitudes.
    assign w_prod   = {w_mul_acc, w_mul_q};
    assign w_prod_s = r_negr ? -w_prod : w_prod;
    assign w_quo_s  = r_negr ? -w_div_q : w_div_q;
    assign w_rem_s  = r_nega ? -w_div_acc : w_div_acc;

    assign w_res_hi = r_isdiv ? w_rem_s : w_prod_s[2*WIDTH-1:WIDTH];
    assign w_res_lo = r_isdiv ? (w_bzero ? '1 : w_quo_s)
                              : w_prod_s[WIDTH-1:0];

    // Control FSM: IDLE/FINISH accept a new op, RUN counts ITER steps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_last) begin
                        r_state <= S_FINISH;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_IDLE, S_FINISH: begin
                    if (Start) begin
                        r_state <= S_RUN;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Operand latch on accept, then one radix-2 step per RUN cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc   <= '0;
            r_q     <= '0;
            r_b     <= '0;
            r_isdiv <= 1'b0;
            r_nega  <= 1'b0;
            r_negr  <= 1'b0;
        end else if (w_accept) begin
            r_acc   <= '0;
            r_q     <= w_absa;
            r_b     <= w_absb;
            r_isdiv <= MdOp[1];
            r_nega  <= w_nega;
            r_negr  <= w_nega ^ w_negb;
        end else if (r_state == S_RUN) begin
            r_acc <= w_next_acc;
            r_q   <= w_next_q;
        end
    end

    // HI/LO: loaded with the result on the last step, mthi/mtlo in IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_last) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
        end else if (r_state == S_IDLE) begin
            if (HiWrite) r_hi <= WrData;
            if (LoWrite) r_lo <= WrData;
        end
    end

    // Completion pulses, high for the single FINISH cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_done <= 1'b0;
            r_dz   <= 1'b0;
        end else begin
            r_done <= w_last;
            r_dz   <= w_last & r_isdiv & w_bzero;
        end
    end

    assign Busy    = r_busy;
    assign Done    = r_done;
    assign DivZero = r_dz;
    assign Hi      = r_hi;
    assign Lo      = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: arithmetic reference model
// compared every cycle, plus directed literal checks.
module tb_mul_div_unit;

    localparam int ITER = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        Start = 1'b0;
    logic [1:0]  MdOp = 2'd0;
    logic [31:0] SrcA = '0;
    logic [31:0] SrcB = '0;
    logic        HiWrite = 1'b0;
    logic        LoWrite = 1'b0;
    logic [31:0] WrData = '0;
    logic        Busy;
    logic        Done;
    logic        DivZero;
    logic [31:0] Hi;
    logic [31:0] Lo;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    mul_div_unit #(.WIDTH(32), .ITER(ITER)) dut (
        .clk(clk), .reset(reset), .Start(Start), .MdOp(MdOp),
        .SrcA(SrcA), .SrcB(SrcB), .HiWrite(HiWrite), .LoWrite(LoWrite),
        .WrData(WrData), .Busy(Busy), .Done(Done), .DivZero(DivZero),
        .Hi(Hi), .Lo(Lo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Reference result {divzero, hi, lo} from plain arithmetic.
    function automatic logic [64:0] model(input logic [1:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'h0, a});
        longint ub = longint'({32'h0, b});
        longint q;
        longint r;
        logic [63:0] p;
        case (op)
            2'd0: begin p = sa * sb; return {1'b0, p}; end
            2'd1: begin p = ua * ub; return {1'b0, p}; end
            default: begin
                if (b == 32'h0) return {1'b1, a, 32'hFFFFFFFF};
                if (op == 2'd2) begin q = sa / sb; r = sa % sb; end
                else begin q = ua / ub; r = ua % ub; end
                return {1'b0, r[31:0], q[31:0]};
            end
        endcase
    endfunction

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic        m_dz = 1'b0;
    int          m_left = 0;
    logic [64:0] m_pend = '0;

    // Cycle-level expectation: pending result lands ITER edges after accept.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_hi <= '0; m_lo <= '0; m_busy <= 1'b0;
            m_done <= 1'b0; m_dz <= 1'b0; m_left <= 0;
        end else if (m_busy) begin
            if (m_left == 1) begin
                m_hi <= m_pend[63:32];
                m_lo <= m_pend[31:0];
                m_dz <= m_pend[64];
                m_done <= 1'b1;
                m_busy <= 1'b0;
                m_left <= 0;
            end else begin
                m_left <= m_left - 1;
                m_done <= 1'b0;
                m_dz <= 1'b0;
            end
        end else begin
            m_done <= 1'b0;
            m_dz <= 1'b0;
            if (!m_done && HiWrite) m_hi <= WrData;
            if (!m_done && LoWrite) m_lo <= WrData;
            if (Start) begin
                m_pend <= model(MdOp, SrcA, SrcB);
                m_busy <= 1'b1;
                m_left <= ITER;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_busy", {31'b0, Busy}, {31'b0, m_busy});
            chk("m_done", {31'b0, Done}, {31'b0, m_done});
            chk("m_divzero", {31'b0, DivZero}, {31'b0, m_dz});
            chk("m_hi", Hi, m_hi);
            chk("m_lo", Lo, m_lo);
        end
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        MdOp = op; SrcA = a; SrcB = b; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0; HiWrite = 1'b0; LoWrite = 1'b0;
    endtask

    task automatic wait_done(output int bc, output bit ok);
        bc = 0;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (Done) begin ok = 1'b1; break; end
            if (Busy) bc++;
            @(negedge clk);
        end
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL done_timeout: got no Done want Done (cyc %0d)", cyc);
        end
    endtask

    task automatic run_op(input string nm, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el,
                          input logic edz);
        int bc;
        bit ok;
        issue(op, a, b);
        wait_done(bc, ok);
        if (ok) begin
            chk({nm, "_busycyc"}, bc, 32);
            chk({nm, "_hi"}, Hi, eh);
            chk({nm, "_lo"}, Lo, el);
            chk({nm, "_dz"}, {31'b0, DivZero}, {31'b0, edz});
        end
        @(negedge clk);
        chk({nm, "_donepulse"}, {31'b0, Done}, 32'h0);
    endtask

    initial begin
        int bc;
        bit ok;
        int t0;
        int seen;
        #1 reset = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", {31'b0, Busy}, 32'h0);
        chk("rst_done", {31'b0, Done}, 32'h0);
        chk("rst_hi", Hi, 32'h0);
        chk("rst_lo", Lo, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        run_op("multu_ff", 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF,
               32'hFFFFFFFE, 32'h00000001, 1'b0);
        run_op("mult_m3x5", 2'd0, 32'hFFFFFFFD, 32'd5,
               32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
        run_op("mult_min", 2'd0, 32'h80000000, 32'h80000000,
               32'h40000000, 32'h0, 1'b0);
        run_op("div_m7d2", 2'd2, 32'hFFFFFFF9, 32'd2,
               32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        run_op("divu_f9d2", 2'd3, 32'hFFFFFFF9, 32'd2,
               32'h1, 32'h7FFFFFFC, 1'b0);
        run_op("div_7dm2", 2'd2, 32'd7, 32'hFFFFFFFE,
               32'h1, 32'hFFFFFFFD, 1'b0);
        LoWrite = 1'b1; WrData = 32'h5555;
        run_op("divu_z", 2'd3, 32'h64, 32'h0,
               32'h64, 32'hFFFFFFFF, 1'b1);
        run_op("div_ovf", 2'd2, 32'h80000000, 32'hFFFFFFFF,
               32'h0, 32'h80000000, 1'b0);
        run_op("div_negz", 2'd2, 32'hFFFFFFF0, 32'h0,
               32'hFFFFFFF0, 32'hFFFFFFFF, 1'b1);

        // Handshake: start while busy is ignored, re-issue in FINISH.
        issue(2'd1, 32'd3, 32'd4);
        repeat (9) @(negedge clk);
        Start = 1'b1; MdOp = 2'd2; SrcA = 32'd100; SrcB = 32'd7;
        HiWrite = 1'b1; WrData = 32'hDEAD;
        @(negedge clk);
        Start = 1'b0; HiWrite = 1'b0;
        chk("hs_busy_ign", {31'b0, Busy}, 32'h1);
        chk("hs_hi_ign", Hi, 32'hFFFFFFF0);
        wait_done(bc, ok);
        t0 = cyc;
        chk("hs_hi", Hi, 32'h0);
        chk("hs_lo", Lo, 32'd12);
        issue(2'd1, 32'd5, 32'd6);
        wait_done(bc, ok);
        chk("hs_b2b_cyc", cyc - t0, 33);
        chk("hs2_lo", Lo, 32'd30);
        HiWrite = 1'b1; WrData = 32'h1111;
        @(negedge clk);
        chk("hs_mthi_fin", Hi, 32'h0);
        WrData = 32'hABCD;
        @(negedge clk);
        HiWrite = 1'b0;
        chk("hs_mthi", Hi, 32'hABCD);
        chk("hs_mthi_lo", Lo, 32'd30);

        // Asynchronous reset in the middle of an operation.
        issue(2'd0, 32'd2, 32'd3);
        repeat (10) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("ar_busy", {31'b0, Busy}, 32'h0);
        chk("ar_hi", Hi, 32'h0);
        chk("ar_lo", Lo, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (Done) seen++;
        end
        chk("ar_nodone", seen, 0);
        run_op("mult_7x6", 2'd0, 32'd7, 32'd6, 32'h0, 32'd42, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
